// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file access arbiter.
// State encoding, default widths and owner-index width helper.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 8;

  // Owner index is exported on a 2-bit port, so never go narrower.
  function automatic int owner_w(input int n);
    return (n <= 4) ? 2 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_rr_picker.sv
// Rotate-priority picker: first req&mask at or above ptr (mod N).
// Ports: req, ptr, mask in; win (one-hot), idx, any out.
module rf_rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (!any && req[k] && mask[k]) begin
        any    = 1'b1;
        win[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one register-file port among NREQ
// requesters, with lock for atomic sequences. Ports: clk, reset
// (async active-low), req/we/lock/addr/wdata per requester, gnt,
// rvalid, rdata, rf_we/rf_addr/rf_wdata/rf_rdata, owner, locked.
// Define RF_ARB_FIXED_PRIO_EN to give requester 0 absolute priority.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  we,
  input  logic [NREQ-1:0]  lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic             rf_we,
  output logic [AW-1:0]    rf_addr,
  output logic [DW-1:0]    rf_wdata,
  input  logic [DW-1:0]    rf_rdata,
  output logic [1:0]       owner,
  output logic             locked
);

  localparam int OW = owner_w(NREQ);

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, ptr_q, nxt_ptr;
  logic [OW-1:0]   pick_idx, sel;
  logic [NREQ-1:0] pick_win, sel_oh, mask, own_oh;
  logic [NREQ-1:0] rvalid_q;
  logic            pick_any, any_req, take;
  logic            s_we, s_lock, locked_q;
  logic [AW-1:0]   rf_addr_q;
  logic [DW-1:0]   rf_wdata_q, rdata_q;

  assign own_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  // In LOCKED only the owner may be picked.
  always_comb begin
    mask = '1;
`ifdef RF_ARB_FIXED_PRIO_EN
    if (state_q == IDLE) mask[0] = 1'b0;
`endif
    if (state_q == LOCKED) mask = own_oh;
  end

  rf_rr_picker #(
    .N  (NREQ),
    .IW (OW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .mask (mask),
    .win  (pick_win),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Core override: rotation only covers 1..NREQ-1 when enabled.
  always_comb begin
    sel     = pick_idx;
    sel_oh  = pick_win;
    any_req = pick_any;
`ifdef RF_ARB_FIXED_PRIO_EN
    if (state_q == IDLE && req[0]) begin
      sel     = '0;
      sel_oh  = {{(NREQ-1){1'b0}}, 1'b1};
      any_req = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE, LOCKED: begin
        if (any_req) begin
          state_d = GRANT;
          take    = 1'b1;
        end
      end
      GRANT:   state_d = s_lock ? LOCKED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign nxt_ptr = (owner_q == OW'(NREQ-1)) ? '0
                 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      s_we       <= 1'b0;
      s_lock     <= 1'b0;
      locked_q   <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= '0;
      if (take) begin
        owner_q    <= sel;
        s_we       <= |(we & sel_oh);
        s_lock     <= |(lock & sel_oh);
        rf_addr_q  <= addr[int'(sel)*AW +: AW];
        rf_wdata_q <= wdata[int'(sel)*DW +: DW];
      end
      if (state_q == GRANT) begin
        locked_q <= s_lock;
        if (!s_lock) ptr_q <= nxt_ptr;
        if (!s_we) begin
          rdata_q  <= rf_rdata;
          rvalid_q <= own_oh;
        end
      end
    end
  end

  assign gnt      = (state_q == GRANT) ? own_oh : '0;
  assign rf_we    = (state_q == GRANT) && s_we;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign owner    = 2'(owner_q);
  assign locked   = locked_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed scoreboard bench for rf_access_arbiter.
// Models the register file and checks grant order and read data.
module tb_rf_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0, we = '0, lock = '0;
  logic [8:0]  addr = '0;
  logic [23:0] wdata = '0;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, rf_wdata, rf_rdata;
  logic        rf_we, locked;
  logic [2:0]  rf_addr;
  logic [1:0]  owner;

  logic [7:0] rf [8] = '{default: 8'h00};
  int mdl [8];
  int exp_gnt [$];
  int exp_rd [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rf_access_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .lock     (lock),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata),
    .owner    (owner),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rf_we) rf[rf_addr] <= rf_wdata;
  assign rf_rdata = rf[rf_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every grant and every read return is popped here.
  always @(negedge clk) begin
    int e;
    int v;
    logic [2:0] ge;
    logic [2:0] re;
    if (gnt != 3'b000) begin
      e  = (exp_gnt.size() > 0) ? exp_gnt.pop_front() : 7;
      ge = (e < 3) ? (3'b001 << e) : 3'b000;
      chk("gnt_order", 32'(gnt), 32'(ge));
    end
    if (rvalid != 3'b000) begin
      v  = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'h7ff;
      re = ((v / 256) < 3) ? (3'b001 << (v / 256)) : 3'b000;
      chk("rd_return", 32'({rvalid, rdata}),
          32'({re, 8'(v % 256)}));
    end
  end

  task automatic acc(input int k, input bit w, input int a,
                     input int d, input bit l, input bit keep,
                     output int gc);
    int n;
    req[k]           = 1'b1;
    we[k]            = w;
    lock[k]          = l;
    addr[k*3 +: 3]   = 3'(a);
    wdata[k*8 +: 8]  = 8'(d);
    exp_gnt.push_back(k);
    if (w) mdl[a] = d;
    else exp_rd.push_back(k * 256 + mdl[a]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[k] && n < 20);
    chk("acc_gnt", 32'(gnt[k]), 32'd1);
    gc = cyc;
    if (!keep) req[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int g, prev, n, n0;
    int cnt [3];
    for (int i = 0; i < 8; i++) mdl[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Preload reg i = i+1, back to back through requester 1.
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      acc(1, 1'b1, i, i + 1, 1'b0, i < 7, g);
      if (i > 0) chk("preload_gap", 32'(g - prev), 32'd2);
      prev = g;
    end
    for (int i = 0; i < 2; i++) begin
      acc(1, 1'b0, i, 0, 1'b0, 1'b0, g);
      @(negedge clk);
      chk("rd_lat", 32'(rvalid), 32'(3'b010));
      chk("rd_data", 32'(rdata), 32'(i + 1));
    end

    // Reset in the middle of a write grant.
    exp_gnt.push_back(1);
    req[1] = 1'b1; we[1] = 1'b1; lock[1] = 1'b0;
    addr[5:3] = 3'd2; wdata[15:8] = 8'h55;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[1] && n < 20);
    chk("rst_mid_gnt_seen", 32'(gnt[1]), 32'd1);
    reset = 1'b0;
    req[1] = 1'b0;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 32'd0);
    chk("rst_mid_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_reg2", 32'(rf[2]), 32'(mdl[2]));
    chk("rst_mid_owner", 32'(owner), 32'd0);
    chk("rst_mid_locked", 32'(locked), 32'd0);

    // All three requesters reading continuously.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) begin
        exp_gnt.push_back(k);
        exp_rd.push_back(k * 256 + mdl[k]);
      end
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    addr = {3'd2, 3'd1, 3'd0};
    we = 3'b000;
    lock = 3'b000;
    req = 3'b111;
    repeat (12) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (gnt[k]) cnt[k]++;
    end
    req = 3'b000;
    for (int k = 0; k < 3; k++) chk("rr_count", 32'(cnt[k]), 32'd2);
    @(negedge clk);

    // Locked read-modify-write by requester 2 while core waits.
    acc(2, 1'b0, 3, 0, 1'b1, 1'b0, g);
    req[0] = 1'b1; we[0] = 1'b0; lock[0] = 1'b0;
    addr[2:0] = 3'd0;
    n0 = 0;
    repeat (3) begin
      @(negedge clk);
      if (gnt[0]) n0++;
    end
    chk("lock_block", 32'(n0), 32'd0);
    chk("lock_flag", 32'(locked), 32'd1);
    chk("lock_owner", 32'(owner), 32'd2);
    acc(2, 1'b1, 3, 5, 1'b0, 1'b0, g);
    exp_gnt.push_back(0);
    exp_rd.push_back(mdl[0]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[0] && n < 20);
    req[0] = 1'b0;
    chk("lock_rel_lat", 32'(n), 32'd2);
    chk("lock_reg3", 32'(rf[3]), 32'd5);
    chk("lock_released", 32'(locked), 32'd0);
    @(negedge clk);

    // Write by core then read by requester 1.
    acc(0, 1'b1, 4, 8'hA0, 1'b0, 1'b0, g);
    acc(1, 1'b0, 4, 0, 1'b0, 1'b0, g);
    @(negedge clk);
    chk("raw_rvalid", 32'(rvalid), 32'(3'b010));
    chk("raw_rdata", 32'(rdata), 32'h0A0);

    // Core and requester 1 competing.
`ifdef RF_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(0);
      exp_rd.push_back(mdl[0]);
    end
`else
    for (int i = 0; i < 2; i++) begin
      exp_gnt.push_back(0);
      exp_rd.push_back(mdl[0]);
      exp_gnt.push_back(1);
      exp_rd.push_back(256 + mdl[1]);
    end
`endif
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    addr = {3'd0, 3'd1, 3'd0};
    we = 3'b000;
    lock = 3'b000;
    req = 3'b011;
    repeat (8) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (gnt[k]) cnt[k]++;
    end
    req = 3'b000;
`ifdef RF_ARB_FIXED_PRIO_EN
    chk("prio_cnt0", 32'(cnt[0]), 32'd4);
    chk("prio_cnt1", 32'(cnt[1]), 32'd0);
`else
    chk("prio_cnt0", 32'(cnt[0]), 32'd2);
    chk("prio_cnt1", 32'(cnt[1]), 32'd2);
`endif

    repeat (3) @(negedge clk);
    chk("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
